// File: rtl/regfile_wb_arbiter_if.sv
// Purpose: bundles the writeback, long-unit, issue and regfile-port signals of
//          regfile_wb_arbiter. Optional perf counters appear when
//          REGFILE_WB_ARB_PERF_EN is defined.
// Ports:   master = producer side (pipeline/long unit/issue), slave = arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_CNT_WIDTH = 16
);
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      lu_valid;
  logic                      lu_ready;
  logic [REG_ADDR_WIDTH-1:0] lu_rd;
  logic [DATA_WIDTH-1:0]     lu_data;
  logic                      issue_valid;
  logic                      issue_long;
  logic [REG_ADDR_WIDTH-1:0] issue_rs1;
  logic [REG_ADDR_WIDTH-1:0] issue_rs2;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic                      stall;
  logic                      RegWrite;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]     ResultW;
`ifdef REGFILE_WB_ARB_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] perf_conflict_cnt;
  logic [PERF_CNT_WIDTH-1:0] perf_starve_cnt;
`endif

  modport master (
    output wb_valid, wb_rd, wb_data,
    output lu_valid, lu_rd, lu_data,
    output issue_valid, issue_long, issue_rs1, issue_rs2, issue_rd,
    input  lu_ready, stall, RegWrite, rd, ResultW
`ifdef REGFILE_WB_ARB_PERF_EN
    , input perf_conflict_cnt, perf_starve_cnt
`endif
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  lu_valid, lu_rd, lu_data,
    input  issue_valid, issue_long, issue_rs1, issue_rs2, issue_rd,
    output lu_ready, stall, RegWrite, rd, ResultW
`ifdef REGFILE_WB_ARB_PERF_EN
    , output perf_conflict_cnt, perf_starve_cnt
`endif
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the regfile write port between the writeback stage (always
//          wins) and a 1-entry long-unit result buffer, with a pending-register
//          scoreboard and a starvation counter that forces an issue bubble.
// Ports:   clk, rst_n (async active-low), bus (regfile_wb_arbiter_if.slave).
//          Optional feature macro: REGFILE_WB_ARB_PERF_EN (saturating perf counters).
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT   = 4,
  parameter int PERF_CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int NREG = 2 ** REG_ADDR_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                      b_full;
  logic [REG_ADDR_WIDTH-1:0] b_rd;
  logic [DATA_WIDTH-1:0]     b_data;
  logic [3:0]                starve_cnt;
  logic [NREG-1:0]           pending;

  logic wb_win;     // pipeline owns the port this cycle
  logic commit;     // buffer drains into the regfile this cycle
  logic accept;     // long-unit handshake
  logic starve;
  logic hazard;
  logic set_pend;

  // wb_rd==0 is a no-op write and therefore leaves the port free.
  assign wb_win   = bus.wb_valid && (bus.wb_rd != '0);
  assign commit   = b_full && !wb_win;
  assign accept   = bus.lu_valid && !b_full;
  assign starve   = (starve_cnt >= LIMIT);
  // Uses pre-edge pending: a register clearing this cycle still stalls.
  assign hazard   = bus.issue_valid &&
                    (pending[bus.issue_rs1] || pending[bus.issue_rs2] ||
                     pending[bus.issue_rd]);
  assign set_pend = bus.issue_valid && bus.issue_long && !bus.stall &&
                    (bus.issue_rd != '0);

  assign bus.lu_ready = !b_full;
  assign bus.stall    = starve || hazard;

  always_comb begin
    bus.RegWrite = 1'b0;
    bus.rd       = '0;
    bus.ResultW  = '0;
    if (wb_win) begin
      bus.RegWrite = 1'b1;
      bus.rd       = bus.wb_rd;
      bus.ResultW  = bus.wb_data;
    end else if (b_full) begin
      bus.RegWrite = 1'b1;
      bus.rd       = b_rd;
      bus.ResultW  = b_data;
    end
  end

  // Accept requires an empty buffer, so accept and commit never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_full <= 1'b0;
      b_rd   <= '0;
      b_data <= '0;
    end else if (accept) begin
      // x0 results are swallowed; the buffer stays empty.
      b_full <= (bus.lu_rd != '0);
      b_rd   <= bus.lu_rd;
      b_data <= bus.lu_data;
    end else if (commit) begin
      b_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (commit) begin
      starve_cnt <= '0;
    end else if (b_full && wb_win && (starve_cnt != 4'hF)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Set is applied after clear so that set wins on the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      if (commit)   pending[b_rd]         <= 1'b0;
      if (set_pend) pending[bus.issue_rd] <= 1'b1;
    end
  end

`ifdef REGFILE_WB_ARB_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] conflict_cnt;
  logic [PERF_CNT_WIDTH-1:0] starve_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt     <= '0;
      starve_stall_cnt <= '0;
    end else begin
      if (b_full && wb_win && !(&conflict_cnt))
        conflict_cnt <= conflict_cnt + 1'b1;
      if (starve && !(&starve_stall_cnt))
        starve_stall_cnt <= starve_stall_cnt + 1'b1;
    end
  end

  assign bus.perf_conflict_cnt = conflict_cnt;
  assign bus.perf_starve_cnt   = starve_stall_cnt;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: self-checking bench for regfile_wb_arbiter; expected regfile writes
//          are queued with their expected cycle and matched at each negedge.
// Ports:   none (top-level bench).
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } wr_t;

  logic clk;
  logic rst_n;
  logic [31:0] cyc;
  int n_tests;
  int n_fail;
  wr_t exp_q[$];

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bif ();

  regfile_wb_arbiter #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = '0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a regfile write in the current cycle.
  task automatic exp_push(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wr_t e;
    e.rd = r; e.data = d; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Write-port monitor: every write must match the head of the queue in
  // address, data and cycle; a queued write whose cycle passes is missing.
  always @(negedge clk) begin
    wr_t e;
    if (bif.RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 64'(bif.rd), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_rd",   64'(bif.rd),      64'(e.rd));
        check("wr_data", 64'(bif.ResultW), 64'(e.data));
        check("wr_cyc",  64'(cyc),         64'(e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("wr_missing", 64'(bif.RegWrite), 64'd1);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bif.wb_valid = 0; bif.wb_rd = '0; bif.wb_data = '0;
    bif.lu_valid = 0; bif.lu_rd = '0; bif.lu_data = '0;
    bif.issue_valid = 0; bif.issue_long = 0;
    bif.issue_rs1 = '0; bif.issue_rs2 = '0; bif.issue_rd = '0;
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    check("rst_lu_ready", 64'(bif.lu_ready), 64'd1);
    check("rst_stall",    64'(bif.stall),    64'd0);
    check("rst_regwrite", 64'(bif.RegWrite), 64'd0);
    check("rst_rd",       64'(bif.rd),       64'd0);
    check("rst_result",   64'(bif.ResultW),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Free port: accept then commit next cycle
    bif.lu_valid = 1; bif.lu_rd = 5; bif.lu_data = 32'h1234;
    @(negedge clk); check("free_rdy_acc", 64'(bif.lu_ready), 64'd1);
    tick();
    bif.lu_valid = 0; exp_push(5, 32'h1234);
    @(negedge clk); check("free_rdy_commit", 64'(bif.lu_ready), 64'd0);
    tick();
    @(negedge clk);
    check("free_rdy_after", 64'(bif.lu_ready), 64'd1);
    check("free_idle_wr",   64'(bif.RegWrite), 64'd0);
    tick();

    // Conflict: wb x3 wins two cycles, x7 drains on the first free cycle
    bif.lu_valid = 1; bif.lu_rd = 7; bif.lu_data = 32'hAA;
    tick();
    bif.lu_valid = 0;
    for (int i = 0; i < 2; i++) begin
      bif.wb_valid = 1; bif.wb_rd = 3; bif.wb_data = 32'h55;
      exp_push(3, 32'h55);
      @(negedge clk); check("conf_rdy_lost", 64'(bif.lu_ready), 64'd0);
      tick();
    end
    bif.wb_valid = 0; exp_push(7, 32'hAA);
    @(negedge clk); check("conf_rdy_commit", 64'(bif.lu_ready), 64'd0);
    tick();
    @(negedge clk); check("conf_rdy_after", 64'(bif.lu_ready), 64'd1);

    // Starvation: 4 lost cycles then stall until the buffer commits
    bif.lu_valid = 1; bif.lu_rd = 7; bif.lu_data = 32'h77;
    bif.wb_valid = 1; bif.wb_rd = 3; bif.wb_data = 32'h100;
    exp_push(3, 32'h100);
    tick();
    bif.lu_valid = 0;
    for (int i = 0; i < 5; i++) begin
      bif.wb_data = 32'h200 + 32'(i);
      exp_push(3, 32'h200 + 32'(i));
      @(negedge clk); check("starve_stall", 64'(bif.stall), (i == 4) ? 64'd1 : 64'd0);
      tick();
    end
    bif.wb_valid = 0; exp_push(7, 32'h77);
    @(negedge clk); check("starve_stall_commit", 64'(bif.stall), 64'd1);
    tick();
    @(negedge clk); check("starve_stall_clear", 64'(bif.stall), 64'd0);
    tick();

    // RAW on x10
    bif.issue_valid = 1; bif.issue_long = 1; bif.issue_rd = 10;
    bif.issue_rs1 = 1; bif.issue_rs2 = 2;
    @(negedge clk); check("raw_issue_long", 64'(bif.stall), 64'd0);
    tick();
    bif.issue_long = 0; bif.issue_rd = 0; bif.issue_rs1 = 10; bif.issue_rs2 = 0;
    @(negedge clk); check("raw_dep", 64'(bif.stall), 64'd1);
    #1 bif.issue_rs1 = 11;
    #1 check("raw_indep", 64'(bif.stall), 64'd0);
    bif.issue_rs1 = 10;
    tick();
    bif.lu_valid = 1; bif.lu_rd = 10; bif.lu_data = 32'hBEEF;
    @(negedge clk); check("raw_dep_acc", 64'(bif.stall), 64'd1);
    tick();
    bif.lu_valid = 0; exp_push(10, 32'hBEEF);
    @(negedge clk); check("raw_dep_commit", 64'(bif.stall), 64'd1);
    tick();
    @(negedge clk); check("raw_released", 64'(bif.stall), 64'd0);
    tick();
    bif.issue_valid = 0;

    // x0: neither path writes, long issue to x0 sets nothing
    bif.lu_valid = 1; bif.lu_rd = 0; bif.lu_data = 32'h999;
    bif.wb_valid = 1; bif.wb_rd = 0; bif.wb_data = 32'h777;
    bif.issue_valid = 1; bif.issue_long = 1; bif.issue_rd = 0;
    bif.issue_rs1 = 0; bif.issue_rs2 = 0;
    @(negedge clk);
    check("x0_regwrite", 64'(bif.RegWrite), 64'd0);
    check("x0_stall",    64'(bif.stall),    64'd0);
    tick();
    bif.lu_valid = 0; bif.wb_valid = 0; bif.issue_long = 0;
    @(negedge clk);
    check("x0_regwrite2", 64'(bif.RegWrite), 64'd0);
    check("x0_rdy",       64'(bif.lu_ready), 64'd1);
    check("x0_no_pend",   64'(bif.stall),    64'd0);
    tick();

    // Reset with full buffer and pending[12]
    bif.issue_valid = 1; bif.issue_long = 1; bif.issue_rd = 12;
    bif.lu_valid = 1; bif.lu_rd = 7; bif.lu_data = 32'h5A;
    bif.wb_valid = 1; bif.wb_rd = 3; bif.wb_data = 32'h31;
    exp_push(3, 32'h31);
    tick();
    bif.lu_valid = 0; bif.issue_long = 0; bif.issue_rd = 0; bif.issue_rs1 = 12;
    bif.wb_data = 32'h32; exp_push(3, 32'h32);
    @(negedge clk);
    check("prerst_stall", 64'(bif.stall),    64'd1);
    check("prerst_rdy",   64'(bif.lu_ready), 64'd0);
    #1;
    bif.wb_valid = 0; rst_n = 1'b0;
    #1 check("rst_async_rdy", 64'(bif.lu_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_rdy",   64'(bif.lu_ready), 64'd1);
    check("postrst_stall", 64'(bif.stall),    64'd0);
    check("postrst_wr",    64'(bif.RegWrite), 64'd0);
    tick();
    bif.issue_valid = 0;
    repeat (2) tick();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback stage and one long-latency unit (mul/div or memory refill). Holds the long-latency result in a 1-entry buffer and writes it back in a cycle the pipeline leaves free. Keeps a per-register pending scoreboard so dependent instructions stall at issue. Sits between the writeback stage, the long-latency unit, the hazard unit and the regfile (RegWrite, rd, ResultW).

Parameters:
DATA_WIDTH, 32, register data width.
REG_ADDR_WIDTH, 5, register index width; 2**REG_ADDR_WIDTH registers.
STARVE_LIMIT, 4, cycles a full buffer may wait before a pipeline bubble is forced; legal range 1..15.
PERF_CNT_WIDTH, 16, width of the performance counters (optional feature only).

Ports:
clk  in  1  clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
wb_valid  in  1  pipeline writeback request; cannot be stalled.
wb_rd  in  REG_ADDR_WIDTH  pipeline destination register.
wb_data  in  DATA_WIDTH  pipeline result.
lu_valid  in  1  long-unit result valid.
lu_ready  out  1  buffer can accept a result.
lu_rd  in  REG_ADDR_WIDTH  long-unit destination register.
lu_data  in  DATA_WIDTH  long-unit result.
issue_valid  in  1  instruction at issue.
issue_long  in  1  issuing instruction targets the long unit.
issue_rs1  in  REG_ADDR_WIDTH  source 1.
issue_rs2  in  REG_ADDR_WIDTH  source 2.
issue_rd  in  REG_ADDR_WIDTH  destination.
stall  out  1  hold issue stage.
RegWrite  out  1  regfile write enable.
rd  out  REG_ADDR_WIDTH  regfile write address.
ResultW  out  DATA_WIDTH  regfile write data.

Behaviour:
- Reset (async, rst_n=0): buffer empty, pending all 0, starve counter 0. Outputs: lu_ready=1, stall=0, RegWrite=0, rd=0, ResultW=0.
- lu_ready = buffer empty. A handshake (lu_valid && lu_ready) loads {lu_rd, lu_data} at posedge. lu_rd==0 is accepted and dropped; the buffer stays empty.
- Write-port mux (combinational): if wb_valid && wb_rd!=0, drive the wb request. Else if the buffer is full, drive the buffer and empty it at posedge. Else RegWrite=0.
- Earliest commit of a long result is the cycle after acceptance. A result cannot be accepted and committed in the same cycle.
- Pipeline writeback always wins the port. wb_valid with wb_rd==0 counts as a free slot.
- Starve counter increments each cycle the buffer is full and loses the port. It clears on buffer commit. At count >= STARVE_LIMIT, stall=1 until the buffer commits, so a bubble reaches writeback.
- Scoreboard: pending[issue_rd] is set at posedge when issue_valid && issue_long && !stall && issue_rd!=0. pending[b_rd] is cleared when the buffer commits. pending[0] is always 0.
- stall = starve || (issue_valid && (pending[issue_rs1] || pending[issue_rs2] || pending[issue_rd])). This covers RAW and WAW.
- stall is computed from pre-edge pending. A register clearing in the current cycle still stalls for that cycle (conservative by one cycle).
- Simultaneous set/clear of the same index cannot occur, because WAW stalls the issue. If both happen anyway, set wins.
- Reset mid-operation discards the buffered result and all pending bits immediately.

Optional Feature:
REGFILE_WB_ARB_PERF_EN
- Defined: adds outputs perf_conflict_cnt and perf_starve_cnt, each PERF_CNT_WIDTH wide, saturating, reset to 0.
- perf_conflict_cnt increments on each cycle a full buffer loses the port to wb.
- perf_starve_cnt increments on each cycle stall is asserted due to starvation.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Free port: lu_valid=1, lu_rd=5, lu_data=0x1234, wb_valid=0 -> next cycle RegWrite=1, rd=5, ResultW=0x1234; lu_ready returns to 1 the cycle after.
- Conflict: buffer holds x7=0xAA while wb_valid=1 with x3=0x55 for 2 cycles -> x3 is written both cycles; x7 is written in the first cycle wb_valid=0; lu_ready stays 0 until then.
- Starvation, STARVE_LIMIT=4: buffer full with wb_valid held high -> stall=1 after 4 lost cycles; when wb_valid drops, x7 commits and stall clears the next cycle.
- RAW: issue long op rd=10, then issue_rs1=10 -> stall=1 until the x10 commit cycle +1; independent rs1=11 -> stall=0.
- x0: lu_rd=0 or wb_rd=0 -> RegWrite never asserted; issue_long with rd=0 leaves pending unchanged, no stall.
- Reset while buffer full and pending[12]=1 -> after rst_n rises, lu_ready=1, stall=0, RegWrite=0, and issue_rs1=12 does not stall.
